ball_ctrl: RTL and testbench
============================

Name: ball_ctrl

Overview:
- Owns ball position, velocity, wall and paddle collisions, and miss detection for the pong game.
- Sits directly upstream of the renderer. Drives ball_on and rgb_ball from the current scan position x,y.
- Issues one-cycle score pulses that the game-state controller consumes.
- Motion advances once per millisecond strobe; all logic runs in the pixel clock domain.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- BALL_SIZE, 8, ball square side in pixels
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- PADDLE1_X, 16, left edge of paddle 1 (left player)
- PADDLE2_X, 616, left edge of paddle 2 (right player)
- SPEED, 2, pixels moved per axis per motion tick
- SERVE_TICKS, 500, motion ticks held at centre before launch
- BALL_COLOR, 12'hFFF, RGB colour of ball

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low
- clk_1ms  in  1  1 ms strobe; rising edge = motion tick
- x  in  10  current scan column
- y  in  10  current scan row
- game_state  in  2  2'b01 = play; any other value = not playing
- paddle1_y  in  10  top edge of paddle 1
- paddle2_y  in  10  top edge of paddle 2
- ball_on  out  1  scan pixel lies inside ball
- rgb_ball  out  12  ball colour (RGB)
- ball_x  out  10  ball left edge
- ball_y  out  10  ball top edge
- score_p1  out  1  one-cycle pulse: player 1 scored (ball passed right wall)
- score_p2  out  1  one-cycle pulse: player 2 scored (ball passed left wall)

Behaviour:
- Reset (reset==0 at clk edge):
  - ball_x=(H_ACTIVE-BALL_SIZE)/2=316, ball_y=(V_ACTIVE-BALL_SIZE)/2=236.
  - dx=+1 (right), dy=+1 (down), tick counter=0, score pulses 0, state IDLE.
  - Reset mid-flight discards motion immediately.
- Tick detect: clk_1ms registered once. tick = clk_1ms & ~clk_1ms_d. Exactly one tick per rising edge, regardless of high duration.
- ball_on = (x>=ball_x)&&(x<ball_x+BALL_SIZE)&&(y>=ball_y)&&(y<ball_y+BALL_SIZE).
  - Combinational from registered position; zero latency.
  - Low in IDLE is not required: the ball is drawn at centre.
- rgb_ball = BALL_COLOR, constant.
- States:
  - IDLE: ball held at centre. game_state==01 -> SERVE, counter cleared.
  - SERVE: counter increments per tick. When counter==SERVE_TICKS-1 and a tick arrives -> MOVE.
  - MOVE: on each tick, apply the update rules below.
  - SCORED: the score pulse is high for this single cycle. Ball recentred; next cycle -> SERVE, counter cleared.
  - Any state: game_state!=01 -> IDLE next cycle, ball recentred. Overrides SCORED, but the pulse still completes if already asserted.
- MOVE update, per tick; x and y resolved independently in the same tick:
  - Vertical:
    - dy up and ball_y<SPEED -> ball_y=0, dy=down.
    - dy down and ball_y+SPEED>V_ACTIVE-BALL_SIZE -> ball_y=V_ACTIVE-BALL_SIZE, dy=up.
    - Otherwise ball_y±=SPEED.
  - Horizontal, moving left:
    - Paddle 1 hit: next left edge <= PADDLE1_X+PADDLE_W, current ball_x >= PADDLE1_X+PADDLE_W, and vertical overlap (ball_y+BALL_SIZE>paddle1_y && ball_y<paddle1_y+PADDLE_H). Then ball_x=PADDLE1_X+PADDLE_W, dx=right.
    - Else if ball_x<SPEED: miss -> score_p2 pulse, SCORED. Next serve direction = left (toward loser).
    - Else ball_x-=SPEED.
  - Horizontal, moving right: mirror image.
    - Paddle face = PADDLE2_X; ball clamps to PADDLE2_X-BALL_SIZE.
    - Miss when ball_x+SPEED>H_ACTIVE-BALL_SIZE: score_p1 pulse, next serve right.
  - Corner case: paddle hit and wall bounce in the same tick both apply.
- Arithmetic: 11-bit intermediates. No wrap is permitted; clamps above guarantee 0<=ball_x<=H_ACTIVE-BALL_SIZE.
- score_p1 and score_p2 are never high simultaneously and never high for more than 1 cycle.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined:
  - Per-axis step is a register, initialised to SPEED on every serve and reset.
  - Each paddle hit increments the step by 1, saturating at 2*SPEED.
  - Clamp and miss rules use the current step.
- Undefined: step fixed at SPEED; no extra registers.

Decomposition:
- Shared package pong_pkg holds:
  - screen constants H_ACTIVE and V_ACTIVE
  - paddle geometry
  - the game_state encoding: IDLE=2'b00, PLAY=2'b01, P1_WIN=2'b10, P2_WIN=2'b11
  - the ball FSM state enum
- One natural sub-module: tick_edge, the 1 ms strobe rising-edge detector. It is reusable by the paddle controller.

Test Plan:
- Reset low 3 cycles with game_state=01 -> ball_x=316, ball_y=236, score pulses 0, ball_on high only for x in 316..323 and y in 236..243.
- game_state=01, apply SERVE_TICKS ticks -> first move on the following tick: ball_x=318, ball_y=238. clk_1ms held high 10 cycles counts as one tick.
- Ball at ball_y=1 moving up, one tick -> ball_y=0, dy=down; next tick ball_y=2.
- Ball moving left at ball_x=25, paddle1_y=200, ball_y=220 -> after tick ball_x=24, dx=right. Same stimulus with paddle1_y=300 -> ball passes; on reaching ball_x<2, score_p2 high exactly 1 cycle, then ball at 316,236.
- game_state switched 01->00 mid-flight -> next cycle IDLE, ball recentred, no score pulse.
- BALL_SPEEDUP_EN defined: three paddle hits -> step 3, 4, 4 (saturated). After a miss, step back to 2.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: screen size, paddle geometry, game_state encoding and ball FSM states.
package pong_pkg;

   localparam int unsigned H_ACTIVE  = 640;
   localparam int unsigned V_ACTIVE  = 480;

   localparam int unsigned PADDLE_W  = 8;
   localparam int unsigned PADDLE_H  = 64;
   localparam int unsigned PADDLE1_X = 16;
   localparam int unsigned PADDLE2_X = 616;

   localparam logic [1:0] GS_IDLE   = 2'b00;
   localparam logic [1:0] GS_PLAY   = 2'b01;
   localparam logic [1:0] GS_P1_WIN = 2'b10;
   localparam logic [1:0] GS_P2_WIN = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StServe,
      StMove,
      StScored
   } ball_state_e;

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector for the 1 ms strobe; one-cycle tick per rising edge of strobe_i.
module tick_edge (
   input  logic clk,
   input  logic reset,
   input  logic strobe_i,
   output logic tick_o
);

   logic strobe_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= strobe_i;
      end
   end

   assign tick_o = strobe_i & ~strobe_q;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball: position, wall/paddle bounces, miss detection, score pulses and ball pixel decode.
// Build option BALL_SPEEDUP_EN: per-axis step grows by one on each paddle hit, up to 2*SPEED.
module ball_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned BALL_SIZE   = 8,
   parameter int unsigned SPEED       = 2,
   parameter int unsigned SERVE_TICKS = 500,
   parameter logic [11:0] BALL_COLOR  = 12'hFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_1ms_i,
   input  logic [9:0]  x_i,
   input  logic [9:0]  y_i,
   input  logic [1:0]  game_state_i,
   input  logic [9:0]  paddle1_y_i,
   input  logic [9:0]  paddle2_y_i,
   output logic        ball_on_o,
   output logic [11:0] rgb_ball_o,
   output logic [9:0]  ball_x_o,
   output logic [9:0]  ball_y_o,
   output logic        score_p1_o,
   output logic        score_p2_o
);

   localparam logic [10:0] Size    = 11'(BALL_SIZE);
   localparam logic [10:0] PadH    = 11'(PADDLE_H);
   localparam logic [10:0] XMax    = 11'(H_ACTIVE - BALL_SIZE);
   localparam logic [10:0] YMax    = 11'(V_ACTIVE - BALL_SIZE);
   localparam logic [9:0]  XCentre = 10'((H_ACTIVE - BALL_SIZE) / 2);
   localparam logic [9:0]  YCentre = 10'((V_ACTIVE - BALL_SIZE) / 2);
   localparam logic [10:0] P1Face  = 11'(PADDLE1_X + PADDLE_W);
   localparam logic [10:0] P2Clamp = 11'(PADDLE2_X - BALL_SIZE);

   localparam int unsigned CntW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SERVE_TICKS - 1);

   ball_state_e     state_q, state_d;
   logic [9:0]      ball_x_q, ball_x_d;
   logic [9:0]      ball_y_q, ball_y_d;
   logic            dx_q, dx_d;     // 1 = moving right
   logic            dy_q, dy_d;     // 1 = moving down
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            score_p1_q, score_p1_d;
   logic            score_p2_q, score_p2_d;

   logic            tick;
   logic            play;
   logic [10:0]     bx, by, p1y, p2y, step;
   logic            p1_overlap, p2_overlap, hit1, hit2;
   logic [9:0]      y_next;
   logic            dy_next;

`ifdef BALL_SPEEDUP_EN
   localparam logic [10:0] StepMax = 11'(2 * SPEED);
   logic [10:0] step_q, step_d;
   assign step = step_q;
`else
   assign step = 11'(SPEED);
`endif

   tick_edge u_tick_edge (
      .clk      (clk),
      .reset    (reset),
      .strobe_i (clk_1ms_i),
      .tick_o   (tick)
   );

   assign play = (game_state_i == GS_PLAY);

   assign bx  = {1'b0, ball_x_q};
   assign by  = {1'b0, ball_y_q};
   assign p1y = {1'b0, paddle1_y_i};
   assign p2y = {1'b0, paddle2_y_i};

   assign p1_overlap = (by + Size > p1y) && (by < p1y + PadH);
   assign p2_overlap = (by + Size > p2y) && (by < p2y + PadH);

   // Hit only when the ball crosses the paddle face this tick from the open-court side.
   assign hit1 = (bx >= P1Face) && (bx - step <= P1Face) && p1_overlap;
   assign hit2 = (bx <= P2Clamp) && (bx + step >= P2Clamp) && p2_overlap;

   always_comb begin
      y_next  = ball_y_q;
      dy_next = dy_q;
      if (!dy_q) begin
         if (by < step) begin
            y_next  = '0;
            dy_next = 1'b1;
         end else begin
            y_next = 10'(by - step);
         end
      end else if (by + step > YMax) begin
         y_next  = 10'(YMax);
         dy_next = 1'b0;
      end else begin
         y_next = 10'(by + step);
      end
   end

   always_comb begin
      state_d    = state_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      cnt_d      = cnt_q;
      score_p1_d = 1'b0;
      score_p2_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
      step_d     = step_q;
`endif

      unique case (state_q)
         StIdle: begin
            ball_x_d = XCentre;
            ball_y_d = YCentre;
            if (play) begin
               state_d = StServe;
               cnt_d   = '0;
            end
         end

         StServe: begin
            if (tick) begin
               if (cnt_q == CntLast) begin
                  state_d = StMove;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end

         StMove: begin
            if (tick) begin
               ball_y_d = y_next;
               dy_d     = dy_next;
               if (!dx_q) begin
                  if (hit1) begin
                     ball_x_d = 10'(P1Face);
                     dx_d     = 1'b1;
`ifdef BALL_SPEEDUP_EN
                     step_d   = (step_q >= StepMax) ? step_q : step_q + 11'd1;
`endif
                  end else if (bx < step) begin
                     score_p2_d = 1'b1;
                     dx_d       = 1'b0;
                     ball_x_d   = XCentre;
                     ball_y_d   = YCentre;
                     state_d    = StScored;
                  end else begin
                     ball_x_d = 10'(bx - step);
                  end
               end else begin
                  if (hit2) begin
                     ball_x_d = 10'(P2Clamp);
                     dx_d     = 1'b0;
`ifdef BALL_SPEEDUP_EN
                     step_d   = (step_q >= StepMax) ? step_q : step_q + 11'd1;
`endif
                  end else if (bx + step > XMax) begin
                     score_p1_d = 1'b1;
                     dx_d       = 1'b1;
                     ball_x_d   = XCentre;
                     ball_y_d   = YCentre;
                     state_d    = StScored;
                  end else begin
                     ball_x_d = 10'(bx + step);
                  end
               end
            end
         end

         StScored: begin
            ball_x_d = XCentre;
            ball_y_d = YCentre;
            state_d  = StServe;
            cnt_d    = '0;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Leaving play wins over everything; a pulse already on the output still completes.
      if (!play) begin
         state_d    = StIdle;
         ball_x_d   = XCentre;
         ball_y_d   = YCentre;
         score_p1_d = 1'b0;
         score_p2_d = 1'b0;
      end

`ifdef BALL_SPEEDUP_EN
      if (state_d == StIdle || state_d == StScored) begin
         step_d = 11'(SPEED);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         ball_x_q   <= XCentre;
         ball_y_q   <= YCentre;
         dx_q       <= 1'b1;
         dy_q       <= 1'b1;
         cnt_q      <= '0;
         score_p1_q <= 1'b0;
         score_p2_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ball_x_q   <= ball_x_d;
         ball_y_q   <= ball_y_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         cnt_q      <= cnt_d;
         score_p1_q <= score_p1_d;
         score_p2_q <= score_p2_d;
      end
   end

`ifdef BALL_SPEEDUP_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         step_q <= 11'(SPEED);
      end else begin
         step_q <= step_d;
      end
   end
`endif

   assign ball_on_o = ({1'b0, x_i} >= bx) && ({1'b0, x_i} < bx + Size) &&
                      ({1'b0, y_i} >= by) && ({1'b0, y_i} < by + Size);

   assign rgb_ball_o = BALL_COLOR;
   assign ball_x_o   = ball_x_q;
   assign ball_y_o   = ball_y_q;
   assign score_p1_o = score_p1_q;
   assign score_p2_o = score_p2_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: reset/pixel table, directed rallies, randomized play vs model.
module tb_ball_ctrl;

   localparam int SPD   = 2;
   localparam int SERVE = 500;
   localparam int BS    = 8;
   localparam int PH    = 64;
   localparam int P1F   = 24;
   localparam int P2X   = 616;
   localparam int XMAX  = 632;
   localparam int YMAX  = 472;
   localparam int XC    = 316;
   localparam int YC    = 236;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_1ms;
   logic [9:0]  x, y, paddle1_y, paddle2_y;
   logic [1:0]  game_state;
   logic        ball_on;
   logic [11:0] rgb_ball;
   logic [9:0]  ball_x, ball_y;
   logic        score_p1, score_p2;

   always #5 clk = ~clk;

   ball_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .clk_1ms_i    (clk_1ms),
      .x_i          (x),
      .y_i          (y),
      .game_state_i (game_state),
      .paddle1_y_i  (paddle1_y),
      .paddle2_y_i  (paddle2_y),
      .ball_on_o    (ball_on),
      .rgb_ball_o   (rgb_ball),
      .ball_x_o     (ball_x),
      .ball_y_o     (ball_y),
      .score_p1_o   (score_p1),
      .score_p2_o   (score_p2)
   );

   int n_err = 0;
   int n_chk = 0;

   // Reference model: signed positions, +1/-1 directions.
   int m_bx, m_by, m_dx, m_dy, m_step, m_cnt;
   bit m_move, m_sp1, m_sp2;
   int pol1, pol2;   // paddle policy: 0 track ball, 1 avoid ball, 2 random

   typedef struct {
      logic [9:0] px;
      logic [9:0] py;
      logic       on;
   } pix_vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit overlaps(input int by, input int p);
      return (by + BS > p) && (by < p + PH);
   endfunction

   function automatic void bump_step();
`ifdef BALL_SPEEDUP_EN
      m_step = (m_step + 1 > 2 * SPD) ? 2 * SPD : m_step + 1;
`endif
   endfunction

   function automatic void model_serve();
      m_move = 1'b0;
      m_cnt  = 0;
      m_bx   = XC;
      m_by   = YC;
      m_step = SPD;
   endfunction

   function automatic void model_tick(input int p1, input int p2);
      int nx, ny;
      m_sp1 = 1'b0;
      m_sp2 = 1'b0;
      if (!m_move) begin
         m_cnt++;
         if (m_cnt == SERVE) begin
            m_move = 1'b1;
            m_cnt  = 0;
         end
         return;
      end
      ny = m_by + m_dy * m_step;
      if (ny < 0) begin
         ny = 0;
         m_dy = 1;
      end else if (ny > YMAX) begin
         ny = YMAX;
         m_dy = -1;
      end
      nx = m_bx + m_dx * m_step;
      if (m_dx < 0) begin
         if (m_bx >= P1F && nx <= P1F && overlaps(m_by, p1)) begin
            nx = P1F;
            m_dx = 1;
            bump_step();
         end else if (nx < 0) begin
            m_sp2 = 1'b1;
            m_dx  = -1;
         end
      end else begin
         if (m_bx + BS <= P2X && nx + BS >= P2X && overlaps(m_by, p2)) begin
            nx = P2X - BS;
            m_dx = -1;
            bump_step();
         end else if (nx > XMAX) begin
            m_sp1 = 1'b1;
            m_dx  = 1;
         end
      end
      m_bx = nx;
      m_by = ny;
      if (m_sp1 || m_sp2) begin
         model_serve();
      end
   endfunction

   function automatic int pick_paddle(input int pol, input int by);
      int p;
      case (pol)
         0: begin
            p = by - int'($urandom_range(0, 56));
            if (p < 0) p = 0;
         end
         1: p = (by < 240) ? 400 : 0;
         default: p = int'($urandom_range(0, 416));
      endcase
      return p;
   endfunction

   // One motion tick: strobe high for `hold` cycles, checks right after the tick and one cycle later.
   task automatic do_tick(input int hold);
      int p1, p2, px, py;
      bit exp_on;
      @(negedge clk);
      p1 = pick_paddle(pol1, m_by);
      p2 = pick_paddle(pol2, m_by);
      paddle1_y = 10'(p1);
      paddle2_y = 10'(p2);
      model_tick(p1, p2);
      px = m_bx - 2 + int'($urandom_range(0, 11));
      py = m_by - 2 + int'($urandom_range(0, 11));
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      x = 10'(px);
      y = 10'(py);
      exp_on = (px >= m_bx) && (px < m_bx + BS) && (py >= m_by) && (py < m_by + BS);
      clk_1ms = 1'b1;
      @(negedge clk);
      chk("tick_ball_x", int'(ball_x), m_bx);
      chk("tick_ball_y", int'(ball_y), m_by);
      chk("tick_score_p1", int'(score_p1), int'(m_sp1));
      chk("tick_score_p2", int'(score_p2), int'(m_sp2));
      chk("tick_ball_on", int'(ball_on), int'(exp_on));
      @(negedge clk);
      chk("pulse_width_p1", int'(score_p1), 0);
      chk("pulse_width_p2", int'(score_p2), 0);
      for (int i = 2; i < hold; i++) @(negedge clk);
      clk_1ms = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b0;
      repeat (cycles) @(negedge clk);
      chk("rst_ball_x", int'(ball_x), XC);
      chk("rst_ball_y", int'(ball_y), YC);
      chk("rst_score_p1", int'(score_p1), 0);
      chk("rst_score_p2", int'(score_p2), 0);
      reset = 1'b1;
      model_serve();
      m_dx = 1;
      m_dy = 1;
   endtask

   task automatic drop_play(input logic [1:0] gs);
      @(negedge clk);
      game_state = gs;
      @(negedge clk);
      chk("drop_ball_x", int'(ball_x), XC);
      chk("drop_ball_y", int'(ball_y), YC);
      chk("drop_score_p1", int'(score_p1), 0);
      chk("drop_score_p2", int'(score_p2), 0);
      repeat (2) @(negedge clk);
      game_state = 2'b01;
      model_serve();
   endtask

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      pix_vec_t vecs[10];
      bit       seen;

      reset      = 1'b0;
      clk_1ms    = 1'b0;
      x          = '0;
      y          = '0;
      game_state = 2'b01;
      paddle1_y  = '0;
      paddle2_y  = '0;
      pol1       = 1;
      pol2       = 1;

      vecs[0] = '{px: 10'd316, py: 10'd236, on: 1'b1};
      vecs[1] = '{px: 10'd323, py: 10'd243, on: 1'b1};
      vecs[2] = '{px: 10'd315, py: 10'd236, on: 1'b0};
      vecs[3] = '{px: 10'd324, py: 10'd236, on: 1'b0};
      vecs[4] = '{px: 10'd316, py: 10'd235, on: 1'b0};
      vecs[5] = '{px: 10'd316, py: 10'd244, on: 1'b0};
      vecs[6] = '{px: 10'd320, py: 10'd240, on: 1'b1};
      vecs[7] = '{px: 10'd0,   py: 10'd0,   on: 1'b0};
      vecs[8] = '{px: 10'd323, py: 10'd236, on: 1'b1};
      vecs[9] = '{px: 10'd316, py: 10'd243, on: 1'b1};

      do_reset(3);
      foreach (vecs[i]) begin
         @(negedge clk);
         x = vecs[i].px;
         y = vecs[i].py;
         #1;
         chk($sformatf("pixel_%0d", i), int'(ball_on), int'(vecs[i].on));
      end
      chk("rgb_ball", int'(rgb_ball), 12'hFFF);

      // Serve: long first strobe still counts once; ball launches on tick SERVE+1.
      do_tick(10);
      repeat (SERVE - 1) do_tick(1);
      chk("serve_hold_x", int'(ball_x), XC);
      chk("serve_hold_y", int'(ball_y), YC);
      do_tick(1);
      chk("first_move_x", int'(ball_x), 318);
      chk("first_move_y", int'(ball_y), 238);

      // Right paddle returns the ball; bottom wall bounce on the way.
      pol1 = 1;
      pol2 = 0;
      repeat (146) do_tick(1);
`ifndef BALL_SPEEDUP_EN
      chk("p2_bounce_x", int'(ball_x), 606);
      chk("p2_bounce_y", int'(ball_y), 416);
`endif

      // Left paddle out of the way: ball misses and player 2 scores.
      pol2 = 1;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         do_tick(1);
         if (m_sp2) seen = 1'b1;
      end
      chk("miss_p2_seen", int'(seen), 1);
      chk("after_miss_x", int'(ball_x), XC);
      chk("after_miss_y", int'(ball_y), YC);

      // Re-serve goes toward the loser (left), then left paddle returns it.
      repeat (SERVE) do_tick(1);
      do_tick(1);
      chk("serve_left_x", int'(ball_x), 314);
      pol1 = 0;
      repeat (146) do_tick(1);
`ifndef BALL_SPEEDUP_EN
      chk("p1_bounce_x", int'(ball_x), 26);
`endif

      do_reset(2);
      repeat (SERVE + 20) do_tick(1);
      drop_play(2'b00);

      for (int i = 0; i < 2500; i++) begin
         if (!m_move) begin
            pol1 = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
            pol2 = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
         end
         do_tick(int'($urandom_range(1, 3)));
         if ($urandom_range(0, 299) == 0) begin
            drop_play(($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(2, 3)));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
